// File: rtl/mat_tile_feeder.sv
// mat_tile_feeder: walks C = A*B element by element. It reads A/B operands over
// 1-cycle-latency ports, accumulates the dot product and streams C out row-major.
module mat_tile_feeder #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MATRIX_WIDTH  = 4,
  parameter int unsigned MATRIX_HEIGHT = 4,
  parameter int unsigned MATRIX_ADJUST = 4,
  localparam int unsigned AAW = (MATRIX_HEIGHT * MATRIX_ADJUST > 1) ? $clog2(MATRIX_HEIGHT * MATRIX_ADJUST) : 1,
  localparam int unsigned BAW = (MATRIX_ADJUST * MATRIX_WIDTH > 1) ? $clog2(MATRIX_ADJUST * MATRIX_WIDTH) : 1,
  localparam int unsigned CAW = (MATRIX_HEIGHT * MATRIX_WIDTH > 1) ? $clog2(MATRIX_HEIGHT * MATRIX_WIDTH) : 1
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic                         istart,
  output logic                         obusy,
  output logic                         odone,
  output logic                         oa_ren,
  output logic [AAW-1:0]               oa_addr,
  input  logic signed [DATA_WIDTH-1:0] ia_rdata,
  output logic                         ob_ren,
  output logic [BAW-1:0]               ob_addr,
  input  logic signed [DATA_WIDTH-1:0] ib_rdata,
  output logic                         oc_wen,
  output logic [CAW-1:0]               oc_addr,
  output logic [DATA_WIDTH-1:0]        oc_wdata,
  input  logic                         ic_ready
);

  // r must be able to hold M: it steps past the last row just before DONE
  localparam int unsigned RW = $clog2(MATRIX_HEIGHT + 1);
  localparam int unsigned CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int unsigned KW = (MATRIX_ADJUST > 1) ? $clog2(MATRIX_ADJUST) : 1;

  typedef enum logic [2:0] {IDLE, READ, MAC, WRITE, DONE} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] prod_c;

  logic                  obusy_q, obusy_d;
  logic                  odone_q, odone_d;
  logic                  oa_ren_q, oa_ren_d;
  logic [AAW-1:0]        oa_addr_q, oa_addr_d;
  logic                  ob_ren_q, ob_ren_d;
  logic [BAW-1:0]        ob_addr_q, ob_addr_d;
  logic                  oc_wen_q, oc_wen_d;
  logic [CAW-1:0]        oc_addr_q, oc_addr_d;
  logic [DATA_WIDTH-1:0] oc_wdata_q, oc_wdata_d;

  // Product is taken at operand width: the low bits equal the truncated full product
  assign prod_c = ia_rdata * ib_rdata;

  // Next-state, index and accumulator update
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (istart) begin
          state_d = READ;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end
      end
      READ: state_d = MAC;
      MAC: begin
        acc_d = ((k_q == '0) ? '0 : acc_q) + prod_c;
        if (k_q == KW'(MATRIX_ADJUST - 1)) begin
          state_d = WRITE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = READ;
        end
      end
      WRITE: begin
        if (ic_ready) begin
          k_d = '0;
          if (c_q != CW'(MATRIX_WIDTH - 1)) begin
            c_d = c_q + CW'(1);
          end else begin
            c_d = '0;
            r_d = r_q + RW'(1);
          end
          if ((r_q == RW'(MATRIX_HEIGHT - 1)) && (c_q == CW'(MATRIX_WIDTH - 1))) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it
  always_comb begin
    obusy_d    = (state_d != IDLE);
    odone_d    = (state_d == DONE);
    oa_ren_d   = (state_d == READ);
    ob_ren_d   = (state_d == READ);
    oc_wen_d   = (state_d == WRITE);
    oa_addr_d  = '0;
    ob_addr_d  = '0;
    oc_addr_d  = '0;
    oc_wdata_d = '0;
    if (oa_ren_d) begin
      oa_addr_d = AAW'(32'(r_d) * MATRIX_ADJUST + 32'(k_d));
      ob_addr_d = BAW'(32'(k_d) * MATRIX_WIDTH + 32'(c_d));
    end
    if (oc_wen_d) begin
      oc_addr_d  = CAW'(32'(r_d) * MATRIX_WIDTH + 32'(c_d));
      oc_wdata_d = acc_d;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      obusy_q    <= 1'b0;
      odone_q    <= 1'b0;
      oa_ren_q   <= 1'b0;
      oa_addr_q  <= '0;
      ob_ren_q   <= 1'b0;
      ob_addr_q  <= '0;
      oc_wen_q   <= 1'b0;
      oc_addr_q  <= '0;
      oc_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      obusy_q    <= obusy_d;
      odone_q    <= odone_d;
      oa_ren_q   <= oa_ren_d;
      oa_addr_q  <= oa_addr_d;
      ob_ren_q   <= ob_ren_d;
      ob_addr_q  <= ob_addr_d;
      oc_wen_q   <= oc_wen_d;
      oc_addr_q  <= oc_addr_d;
      oc_wdata_q <= oc_wdata_d;
    end
  end

  assign obusy    = obusy_q;
  assign odone    = odone_q;
  assign oa_ren   = oa_ren_q;
  assign oa_addr  = oa_addr_q;
  assign ob_ren   = ob_ren_q;
  assign ob_addr  = ob_addr_q;
  assign oc_wen   = oc_wen_q;
  assign oc_addr  = oc_addr_q;
  assign oc_wdata = oc_wdata_q;

endmodule
